// File: rtl/sram_responder.sv
// SRAM stand-in for the LC-3 memory port: serves active-low CE/OE/WE/UB/LB
// strobes from an internal word array with a fixed, parameterised read latency.
module sram_responder #(
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CE_N,
    input  logic        OE_N,
    input  logic        WE_N,
    input  logic        UB_N,
    input  logic        LB_N,
    input  logic [19:0] ADDR,
    input  logic [15:0] Data_in,
    output logic [15:0] Data_out,
    output logic        Data_valid,
    output logic        Wr_done
);

    localparam int         AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] LAST = 3'(READ_LAT - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_HOLD, WR_ACTIVE} state_t;

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] addr, rd_addr, wr_addr;
    logic [15:0]   wr_data;
    logic [1:0]    wr_lanes;
    logic [2:0]    cnt;
    logic          write, read, commit, addr_chg;
    logic [15:0]   lane_mask, rd_word;
    logic          addr_unused;

    // Upper address bits alias onto the array.
    assign addr        = ADDR[AW-1:0];
    assign addr_unused = ^ADDR[19:AW];

    assign write     = !CE_N && !WE_N;
    assign read      = !CE_N && !OE_N && WE_N;
    assign commit    = (state == WR_ACTIVE) && !write;
    assign addr_chg  = (addr != rd_addr);
    assign lane_mask = {{8{!UB_N}}, {8{!LB_N}}};
    assign rd_word   = mem[rd_addr] & lane_mask;

    // Array is deliberately outside reset so contents survive a Reset pulse.
    always_ff @(posedge Clk) begin
        if (commit) begin
            if (wr_lanes[1]) mem[wr_addr][15:8] <= wr_data[15:8];
            if (wr_lanes[0]) mem[wr_addr][7:0]  <= wr_data[7:0];
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            Data_out   <= 16'h0000;
            Data_valid <= 1'b0;
            Wr_done    <= 1'b0;
            cnt        <= 3'd0;
            rd_addr    <= '0;
            wr_addr    <= '0;
            wr_data    <= 16'h0000;
            wr_lanes   <= 2'b00;
        end else begin
            Wr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (write) begin
                        wr_addr  <= addr;
                        wr_data  <= Data_in;
                        wr_lanes <= {!UB_N, !LB_N};
                        state    <= WR_ACTIVE;
                    end else if (read) begin
                        rd_addr <= addr;
                        cnt     <= 3'd1;
                        state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (write) begin
                        wr_addr  <= addr;
                        wr_data  <= Data_in;
                        wr_lanes <= {!UB_N, !LB_N};
                        state    <= WR_ACTIVE;
                    end else if (!read) begin
                        state <= IDLE;
                    end else if (addr_chg) begin
                        rd_addr <= addr;
                        cnt     <= 3'd1;
                    end else if (cnt == LAST) begin
                        Data_out   <= rd_word;
                        Data_valid <= 1'b1;
                        state      <= RD_HOLD;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                RD_HOLD: begin
                    if (write) begin
                        wr_addr    <= addr;
                        wr_data    <= Data_in;
                        wr_lanes   <= {!UB_N, !LB_N};
                        Data_valid <= 1'b0;
                        state      <= WR_ACTIVE;
                    end else if (!read) begin
                        Data_valid <= 1'b0;
                        state      <= IDLE;
                    end else if (addr_chg) begin
                        Data_valid <= 1'b0;
                        rd_addr    <= addr;
                        cnt        <= 3'd1;
                        state      <= RD_WAIT;
                    end
                end
                WR_ACTIVE: begin
                    if (write) begin
                        wr_addr  <= addr;
                        wr_data  <= Data_in;
                        wr_lanes <= {!UB_N, !LB_N};
                    end else begin
                        // Array commits on this edge; a read issued now sees the new word.
                        Wr_done <= 1'b1;
                        if (read) begin
                            rd_addr <= addr;
                            cnt     <= 3'd1;
                            state   <= RD_WAIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the LC-3 datapath's SRAM interface. It sits on the far end of the active-low CE/OE/WE/UB/LB strobes driven by the control unit and serves reads and writes from an internal word array. Reads return data after a fixed, parameterised number of OE-low cycles. Writes are committed when WE deasserts. The block stands in for the board SRAM in simulation and small on-chip builds, and defines the timing the control unit's memory states must honour.

## Interface
- DEPTH = 1024 — number of 16-bit words; power of two, 2..65536.
- READ_LAT = 2 — OE-low cycles until Data_out is valid; legal range 2..7.
- Clk  in  1  — single clock; all state changes on rising edge.
- Reset  in  1  — asynchronous, active-low (0 = reset).
- CE_N  in  1  — chip enable, active-low.
- OE_N  in  1  — output enable (read), active-low.
- WE_N  in  1  — write enable, active-low; wins over OE_N.
- UB_N  in  1  — upper byte lane [15:8] enable, active-low.
- LB_N  in  1  — lower byte lane [7:0] enable, active-low.
- ADDR  in  20  — word address; only the low log2(DEPTH) bits are used.
- Data_in  in  16  — write data (from MDR).
- Data_out  out  16  — registered read data.
- Data_valid  out  1  — Data_out holds data for the current read address.
- Wr_done  out  1  — one-cycle pulse on the cycle after a write commits.

## Operation
- States: IDLE, RD_WAIT, RD_HOLD, WR_ACTIVE.
- Request decode, per edge:
  - write = !CE_N & !WE_N
  - read = !CE_N & !OE_N & WE_N
- IDLE:
  - write → latch ADDR/Data_in/lanes, go WR_ACTIVE.
  - read → latch ADDR, load counter = 1, go RD_WAIT.
  - otherwise stay.
- RD_WAIT:
  - write → abort read, latch, go WR_ACTIVE.
  - read negated → IDLE.
  - ADDR differs from latched → re-latch, counter = 1.
  - counter == READ_LAT-1 → Data_out <= masked array word, Data_valid = 1, go RD_HOLD.
  - otherwise counter++.
- RD_HOLD:
  - Data_out and Data_valid = 1 held while read persists with the same ADDR.
  - ADDR change → Data_valid = 0, re-latch, counter = 1, go RD_WAIT.
  - write → WR_ACTIVE.
  - read negated → IDLE, Data_valid = 0.
- Read lane masking: a lane whose UB_N/LB_N is high returns 0x00 in its byte. Lanes are sampled on the same edge as the data load.
- WR_ACTIVE:
  - Each edge with write asserted re-latches address, data and lanes (last-value-wins).
  - First edge with write negated: commit the latched data to enabled lanes only, Wr_done = 1 next cycle.
  - On that same commit edge: if read is asserted, latch ADDR and go RD_WAIT with counter = 1; else go IDLE.
- Both lanes disabled during write: commit nothing; Wr_done still pulses.
- Address wrap: ADDR[19:log2(DEPTH)] ignored; ADDR = DEPTH aliases word 0.
- Array contents are not cleared by Reset. Simulation initial value is 0x0000.

## Timing
- Reset values: state IDLE, Data_out = 0x0000, Data_valid = 0, Wr_done = 0, counter = 0, write latches cleared.
- Reset asserted mid-write drops the pending commit: the array is unchanged and there is no Wr_done.
- Read latency: OE_N/CE_N low first sampled at edge E0 → Data_out/Data_valid update at edge E0+READ_LAT-1. With READ_LAT=2, data is valid during the second OE-low cycle, so it can be loaded into MDR at the end of that cycle.
- Write: the array updates at the first edge where WE_N=1 (or CE_N=1) is sampled after WE_N low. Wr_done is high for exactly the following cycle.
- Read-after-write to the same address, with OE asserted in the cycle WE_N rises, returns the new data (the array is updated before the read's data-load edge).
- Data_out is never combinational from inputs. Data_valid drops one edge after the read ends.

## Test plan
- Reset low mid-RD_WAIT → Data_out = 0x0000, Data_valid = 0 asynchronously. Release, then idle 3 cycles → no Wr_done.
- Write 0xBEEF to ADDR 0x00005 (WE_N low 1 cycle, both lanes), then OE_N low 2 cycles → Data_valid rises on the 2nd cycle, Data_out = 0xBEEF; Wr_done pulses once.
- WE_N held low 5 cycles with Data_in stepping 0x1111→0x5555 → after WE_N rises, word = 0x5555 and exactly one Wr_done.
- Pre-load 0x1234, write 0xABCD with UB_N=1, LB_N=0 → read back 0x12CD. Read with LB_N=1 → 0x1200.
- READ_LAT=4, OE_N low at ADDR 3, ADDR changes to 7 on the 2nd cycle → Data_valid first rises 4 cycles after the change, Data_out = word 7.
- DEPTH=1024, write 0x00FF at ADDR 0x00400 → a read at ADDR 0x00000 returns 0x00FF. WE_N and OE_N low together → a write occurs and Data_valid stays 0.
